// File: rtl/dir_queue_ctrl_if.sv
// Bundle of the movement-tick, button and heading-queue status signals shared
// between the snake game logic and the direction queue controller.
interface dir_queue_ctrl_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          game_en;
    logic          pause;
    logic          dead;
    logic          isUp;
    logic          isDown;
    logic          isLeft;
    logic          isRight;
    logic [1:0]    dir;
    logic          step;
    logic [CW-1:0] count;
    logic          full;
    logic          drop;
    logic [1:0]    state;

    modport master (
        output game_en, pause, dead, isUp, isDown, isLeft, isRight,
        input  dir, step, count, full, drop, state
    );

    modport slave (
        input  game_en, pause, dead, isUp, isDown, isLeft, isRight,
        output dir, step, count, full, drop, state
    );
endinterface

// File: rtl/dir_queue_ctrl.sv
// Snake heading controller: queues legal button turns and applies one per
// movement tick, with RUN/PAUSED/HALT game-state handling.
module dir_queue_ctrl #(
    parameter int         DEPTH    = 4,
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input  logic             clk,
    input  logic             rst,
    dir_queue_ctrl_if.slave  bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    // UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    state_t        state_r;
    logic [1:0]    dir_r;
    logic          step_r;
    logic          drop_r;
    logic [CW-1:0] count_r;
    logic          full_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [3:0]    prev_r;
    logic          armed_r;
    logic [1:0]    mem_r [DEPTH];

    logic [3:0]    btn_s;
    logic [3:0]    edge_s;
    logic [1:0]    press_dir_s;
    logic [1:0]    ref_dir_s;
    logic [AW-1:0] tail_s;
    logic          run_live_s;
    logic          tick_s;
    logic          pop_s;
    logic          press_s;
    logic          legal_s;
    logic          room_s;
    logic          push_s;
    logic          reject_s;
    logic          flush_s;
    logic [CW-1:0] count_next_s;
    state_t        state_next_s;

    assign btn_s  = {bus.isUp, bus.isDown, bus.isLeft, bus.isRight};
    assign edge_s = btn_s & ~prev_r;

    // Pick the single winning new press, UP highest priority.
    always_comb begin
        press_dir_s = 2'd0;
        if (edge_s[3]) begin
            press_dir_s = 2'd0;
        end else if (edge_s[2]) begin
            press_dir_s = 2'd1;
        end else if (edge_s[1]) begin
            press_dir_s = 2'd2;
        end else if (edge_s[0]) begin
            press_dir_s = 2'd3;
        end else begin
            press_dir_s = 2'd0;
        end
    end

    // Validate the press against the last queued heading, and derive tick/pop.
    always_comb begin
        tail_s     = wr_ptr_r - AW'(1);
        ref_dir_s  = (count_r != {CW{1'b0}}) ? mem_r[tail_s] : dir_r;
        run_live_s = (state_r == ST_RUN) && !bus.dead;
        tick_s     = run_live_s && !bus.pause && bus.game_en;
        pop_s      = tick_s && (count_r != {CW{1'b0}});
        press_s    = armed_r && run_live_s && (edge_s != 4'b0000);
        legal_s    = (press_dir_s != ref_dir_s) && (press_dir_s != opposite_dir(ref_dir_s));
        room_s     = (count_r != DEPTH_C) || pop_s;
        push_s     = press_s && legal_s && room_s;
        reject_s   = press_s && !push_s;
        flush_s    = bus.dead || (state_r == ST_HALT);
    end

    // Occupancy update; simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next_s = count_r;
        if (flush_s) begin
            count_next_s = {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CW'(1);
                2'b01:   count_next_s = count_r - CW'(1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // Game-state transitions; dead outranks pause and HALT is sticky.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (bus.dead) begin
                    state_next_s = ST_HALT;
                end else if (bus.pause) begin
                    state_next_s = ST_PAUSED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (bus.dead) begin
                    state_next_s = ST_HALT;
                end else if (!bus.pause) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_PAUSED;
                end
            end
            ST_HALT:  state_next_s = ST_HALT;
            default:  state_next_s = ST_HALT;
        endcase
    end

    // Control state, pointers, heading and output pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_RUN;
            dir_r    <= INIT_DIR;
            step_r   <= 1'b0;
            drop_r   <= 1'b0;
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            prev_r   <= btn_s;
            armed_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            step_r  <= tick_s;
            drop_r  <= reject_s;
            count_r <= count_next_s;
            full_r  <= (count_next_s == DEPTH_C);
            prev_r  <= btn_s;
            armed_r <= 1'b1;
            if (flush_s) begin
                rd_ptr_r <= {AW{1'b0}};
                wr_ptr_r <= {AW{1'b0}};
                dir_r    <= dir_r;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                    dir_r    <= mem_r[rd_ptr_r];
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                    dir_r    <= dir_r;
                end
            end
        end
    end

    // Queue storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= press_dir_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign bus.dir   = dir_r;
    assign bus.step  = step_r;
    assign bus.drop  = drop_r;
    assign bus.count = count_r;
    assign bus.full  = full_r;
    assign bus.state = state_r;
endmodule
